// File: rtl/divvec_if.sv
// Valid/ready handshake bundle for the SIMD vector divider: operand side and result side.
interface divvec_if #(
  parameter int VLEN  = 128,
  parameter int SEL_W = 3
);
  logic             valid_in;
  logic             ready_out;
  logic [VLEN-1:0]  srca_in;
  logic [VLEN-1:0]  srcb_in;
  logic [SEL_W-1:0] sel_in;
  logic             is_rem_in;
  logic             is_signed_in;
  logic             valid_out;
  logic             ready_in;
  logic [VLEN-1:0]  result_out;

  modport slave (
    input  valid_in, srca_in, srcb_in, sel_in, is_rem_in, is_signed_in, ready_in,
    output ready_out, valid_out, result_out
  );

  modport master (
    output valid_in, srca_in, srcb_in, sel_in, is_rem_in, is_signed_in, ready_in,
    input  ready_out, valid_out, result_out
  );
endinterface

// File: rtl/divvec_iterative.sv
// Iterative SIMD restoring divider: 128-bit vectors split into 8..128-bit lanes,
// one quotient bit per lane per cycle, RISC-V divide-by-zero and overflow results.
module divvec_iterative #(
  parameter int VLEN  = 128,
  parameter int SEL_W = 3
) (
  input logic      clk,
  input logic      rst_n,
  divvec_if.slave  bus
);
  localparam int NL = 16;  // lane count at the narrowest element width

  typedef enum logic [1:0] {IDLE, BUSY, FIX, DONE} state_t;

  state_t          state;
  logic [VLEN-1:0] rem_q, quo_q, dvs_q;
  logic [NL-1:0]   sa_q, sb_q, z_q, o_q;
  logic            is_rem_q, illegal_q;
  logic [2:0]      sel_q;
  logic [7:0]      cnt_q;

  logic            illegal_in;
  logic [2:0]      sel_eff;

  assign illegal_in = (bus.sel_in > SEL_W'(4));
  assign sel_eff    = illegal_in ? 3'd0 : bus.sel_in[2:0];

  // Per-width datapaths; the active one is chosen by the element-size select.
  logic [VLEN-1:0] a_mag_w [5];
  logic [VLEN-1:0] b_mag_w [5];
  logic [VLEN-1:0] rem_nx_w [5];
  logic [VLEN-1:0] quo_nx_w [5];
  logic [VLEN-1:0] res_w [5];
  logic [NL-1:0]   sa_w [5];
  logic [NL-1:0]   sb_w [5];
  logic [NL-1:0]   z_w [5];
  logic [NL-1:0]   o_w [5];

  for (genvar g = 0; g < 5; g++) begin : g_w
    localparam int W = 8 << g;
    localparam int N = VLEN / W;
    logic [VLEN-1:0] a_mag, b_mag, rem_nx, quo_nx, res;
    logic [N-1:0]    sa, sb, z, o;

    for (genvar l = 0; l < N; l++) begin : g_l
      logic [W-1:0] a, b, r, q, d, qf, rf;
      logic [W:0]   sh;
      logic         ge;

      assign a = bus.srca_in[l*W +: W];
      assign b = bus.srcb_in[l*W +: W];
      assign sa[l] = bus.is_signed_in & a[W-1];
      assign sb[l] = bus.is_signed_in & b[W-1];
      assign a_mag[l*W +: W] = sa[l] ? -a : a;
      assign b_mag[l*W +: W] = sb[l] ? -b : b;
      assign z[l] = (b == '0);
      assign o[l] = bus.is_signed_in & (a == {1'b1, {(W-1){1'b0}}}) & (&b);

      // One restoring step: shift the next dividend bit into the partial remainder.
      assign r  = rem_q[l*W +: W];
      assign q  = quo_q[l*W +: W];
      assign d  = dvs_q[l*W +: W];
      assign sh = {r, q[W-1]};
      assign ge = (sh >= {1'b0, d});
      assign rem_nx[l*W +: W] = ge ? W'(sh - {1'b0, d}) : sh[W-1:0];
      assign quo_nx[l*W +: W] = {q[W-2:0], ge};

      // Sign restoration and the zero-divisor / overflow overrides.
      assign qf = z_q[l] ? {W{1'b1}} :
                  o_q[l] ? {1'b1, {(W-1){1'b0}}} :
                  (sa_q[l] ^ sb_q[l]) ? -q : q;
      assign rf = o_q[l] ? '0 : (sa_q[l] ? -r : r);
      assign res[l*W +: W] = is_rem_q ? rf : qf;
    end

    assign a_mag_w[g]  = a_mag;
    assign b_mag_w[g]  = b_mag;
    assign rem_nx_w[g] = rem_nx;
    assign quo_nx_w[g] = quo_nx;
    assign res_w[g]    = res;
    assign sa_w[g]     = NL'(sa);
    assign sb_w[g]     = NL'(sb);
    assign z_w[g]      = NL'(z);
    assign o_w[g]      = NL'(o);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state          <= IDLE;
      bus.valid_out  <= 1'b0;
      bus.ready_out  <= 1'b1;
      bus.result_out <= '0;
      rem_q          <= '0;
      quo_q          <= '0;
      dvs_q          <= '0;
      sa_q           <= '0;
      sb_q           <= '0;
      z_q            <= '0;
      o_q            <= '0;
      is_rem_q       <= 1'b0;
      illegal_q      <= 1'b0;
      sel_q          <= '0;
      cnt_q          <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.valid_in && bus.ready_out) begin
            rem_q         <= '0;
            quo_q         <= a_mag_w[sel_eff];
            dvs_q         <= b_mag_w[sel_eff];
            sa_q          <= sa_w[sel_eff];
            sb_q          <= sb_w[sel_eff];
            z_q           <= z_w[sel_eff];
            o_q           <= o_w[sel_eff];
            is_rem_q      <= bus.is_rem_in;
            illegal_q     <= illegal_in;
            sel_q         <= sel_eff;
            cnt_q         <= 8'd8 << sel_eff;
            bus.ready_out <= 1'b0;
            state         <= BUSY;
          end
        end
        BUSY: begin
          rem_q <= rem_nx_w[sel_q];
          quo_q <= quo_nx_w[sel_q];
          cnt_q <= cnt_q - 8'd1;
          if (cnt_q == 8'd1) state <= FIX;
        end
        FIX: begin
          bus.result_out <= illegal_q ? '0 : res_w[sel_q];
          bus.valid_out  <= 1'b1;
          state          <= DONE;
        end
        DONE: begin
          if (bus.ready_in) begin
            bus.valid_out <= 1'b0;
            bus.ready_out <= 1'b1;
            state         <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
